// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: one access at a time,
// LATENCY wait states, combinational stall, registered ack/rdata. Optional DMEM_PERF_CNT_EN adds stall_cnt.
module dmem_responder #(
    parameter int ADDR_W  = 5,
    parameter int DEPTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ack,
    output logic              stall,
    output logic [1:0]        state_dbg
`ifdef DMEM_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    // Handshake: the MEM stage holds req/we/addr/wdata until ack; stall is the
    // inverse of ready and the request is taken on the IDLE edge where req=1.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    state_t              state, next_state;
    logic [3:0]          wait_cnt;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic [31:0]         mem [DEPTH];

    logic                accept;
    logic                commit;
    logic                eff_we;
    logic [ADDR_W-1:0]   eff_addr;
    logic [31:0]         eff_wdata;

    always_comb begin
        next_state = state;
        stall      = 1'b0;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    stall      = 1'b1;
                    accept     = 1'b1;
                    next_state = (LATENCY == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                stall = 1'b1;
                if (wait_cnt == 4'd0) begin
                    next_state = S_RESP;
                end
            end
            S_RESP: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // With zero latency the commit happens on the accepting edge, before the
    // latched copies exist, so the live inputs are used in IDLE.
    always_comb begin
        commit    = (next_state == S_RESP);
        eff_we    = (state == S_IDLE) ? we    : we_q;
        eff_addr  = (state == S_IDLE) ? addr  : addr_q;
        eff_wdata = (state == S_IDLE) ? wdata : wdata_q;
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state    <= S_IDLE;
            wait_cnt <= 4'd0;
            ack      <= 1'b0;
            rdata    <= 32'd0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= 32'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'd0;
            end
        end else begin
            state <= next_state;
            ack   <= commit;
            if (accept) begin
                we_q     <= we;
                addr_q   <= addr;
                wdata_q  <= wdata;
                wait_cnt <= LAT_M1;
            end else if (state == S_WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (commit) begin
                if (eff_we) begin
                    mem[eff_addr] <= eff_wdata;
                end else begin
                    rdata <= mem[eff_addr];
                end
            end
        end
    end

    assign state_dbg = state;

`ifdef DMEM_PERF_CNT_EN
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            stall_cnt <= 32'd0;
        end else if (stall && stall_cnt != 32'hFFFF_FFFF) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2 and a LATENCY=0 instance checked against
// an array-based memory model with per-cycle stall/ack expectations.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        resetn;
    always #5 clk = ~clk;

    logic        req2, we2, ack2, stall2;
    logic [4:0]  addr2;
    logic [31:0] wdata2, rdata2;
    logic [1:0]  st2;
    logic        req0, we0, ack0, stall0;
    logic [4:0]  addr0;
    logic [31:0] wdata0, rdata0;
    logic [1:0]  st0;
`ifdef DMEM_PERF_CNT_EN
    logic [31:0] cnt2, cnt0;
`endif

    dmem_responder #(.ADDR_W(5), .DEPTH(32), .LATENCY(2)) dut2 (
        .Clock(clk), .Resetn(resetn), .req(req2), .we(we2), .addr(addr2),
        .wdata(wdata2), .rdata(rdata2), .ack(ack2), .stall(stall2), .state_dbg(st2)
`ifdef DMEM_PERF_CNT_EN
        , .stall_cnt(cnt2)
`endif
    );

    dmem_responder #(.ADDR_W(5), .DEPTH(32), .LATENCY(0)) dut0 (
        .Clock(clk), .Resetn(resetn), .req(req0), .we(we0), .addr(addr0),
        .wdata(wdata0), .rdata(rdata0), .ack(ack0), .stall(stall0), .state_dbg(st0)
`ifdef DMEM_PERF_CNT_EN
        , .stall_cnt(cnt0)
`endif
    );

    // Reference model: memory contents, last load value and stall-edge count per instance.
    logic [31:0] mm2 [32];
    logic [31:0] mm0 [32];
    logic [31:0] mr2, mr0;
    logic [31:0] mc2, mc0;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) begin
            mm2[i] = 32'd0;
            mm0[i] = 32'd0;
        end
        mr2 = 32'd0;
        mr0 = 32'd0;
        mc2 = 32'd0;
        mc0 = 32'd0;
    endtask

    task automatic drive(input bit sel, input logic r, input logic w,
                         input logic [4:0] a, input logic [31:0] d);
        if (sel) begin
            req2 = r; we2 = w; addr2 = a; wdata2 = d; req0 = 1'b0;
        end else begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d; req2 = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        req2 = 1'b0;
        req0 = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_stall2", {31'd0, stall2}, 32'd0);
            check("idle_ack2",   {31'd0, ack2},   32'd0);
            check("idle_stall0", {31'd0, stall0}, 32'd0);
            check("idle_ack0",   {31'd0, ack0},   32'd0);
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset(input int n);
        resetn = 1'b0;
        req2 = 1'b0;
        req0 = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
        resetn = 1'b1;
        clear_model();
    endtask

    // One complete access: request held from cycle 0 through the ack cycle.
    // With junk set, addr/wdata/we are scrambled during the wait cycles.
    task automatic access(input bit sel, input bit w, input logic [4:0] a,
                          input logic [31:0] d, input bit junk);
        int          lat;
        logic [31:0] exp_rd;
        logic        nw;
        logic [4:0]  na;
        logic [31:0] nd;
        lat = sel ? 2 : 0;
        if (w) begin
            if (sel) mm2[a] = d; else mm0[a] = d;
        end else begin
            if (sel) mr2 = mm2[a]; else mr0 = mm0[a];
        end
        exp_rd = sel ? mr2 : mr0;
        for (int c = 0; c <= lat + 1; c++) begin
            nw = w; na = a; nd = d;
            if (junk && c >= 1 && c <= lat) begin
                nw = 1'($urandom);
                na = 5'($urandom);
                nd = $urandom;
            end
            drive(sel, 1'b1, nw, na, nd);
            @(negedge clk);
            check(sel ? "stall_l2" : "stall_l0", {31'd0, sel ? stall2 : stall0},
                  (c <= lat) ? 32'd1 : 32'd0);
            check(sel ? "ack_l2" : "ack_l0", {31'd0, sel ? ack2 : ack0},
                  (c == lat + 1) ? 32'd1 : 32'd0);
            if (c == lat + 1) begin
                check(sel ? "rdata_l2" : "rdata_l0", sel ? rdata2 : rdata0, exp_rd);
`ifdef DMEM_PERF_CNT_EN
                check(sel ? "stall_cnt_l2" : "stall_cnt_l0", sel ? cnt2 : cnt0, sel ? mc2 : mc0);
`endif
            end
            @(posedge clk); #1;
            if (c <= lat) begin
                if (sel) mc2 = mc2 + 32'd1; else mc0 = mc0 + 32'd1;
            end
        end
    endtask

    initial begin
        resetn = 1'b0;
        req2 = 1'b0; we2 = 1'b0; addr2 = 5'd0; wdata2 = 32'd0;
        req0 = 1'b0; we0 = 1'b0; addr0 = 5'd0; wdata0 = 32'd0;
        clear_model();

        do_reset(3);
        @(negedge clk);
        check("reset_rdata2", rdata2, 32'd0);
        check("reset_rdata0", rdata0, 32'd0);
        check("reset_ack2",   {31'd0, ack2}, 32'd0);
        check("reset_stall2", {31'd0, stall2}, 32'd0);
`ifdef DMEM_PERF_CNT_EN
        check("reset_cnt2", cnt2, 32'd0);
`endif
        @(posedge clk); #1;

        // Store then load on the LATENCY=2 instance.
        access(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
        access(1'b1, 1'b0, 5'd5, 32'd0, 1'b0);
        check("load5_value", rdata2, 32'hDEADBEEF);
        access(1'b1, 1'b0, 5'd6, 32'd0, 1'b0);
        check("load6_value", rdata2, 32'd0);
`ifdef DMEM_PERF_CNT_EN
        check("three_access_cnt", cnt2, 32'd9);
`endif
        idle(1);

        // Zero latency: held req in the ack cycle must not start a second access.
        access(1'b0, 1'b0, 5'd7, 32'd0, 1'b0);
        access(1'b0, 1'b1, 5'd7, 32'h0000_1234, 1'b0);
        access(1'b0, 1'b0, 5'd7, 32'd0, 1'b0);
        check("l0_load7", rdata0, 32'h0000_1234);
        idle(2);

        // Back-to-back with inputs scrambled while waiting.
        access(1'b1, 1'b1, 5'd31, 32'd1, 1'b1);
        access(1'b1, 1'b0, 5'd31, 32'd0, 1'b1);
        check("b2b_load31", rdata2, 32'd1);
        access(1'b1, 1'b1, 5'd0, 32'hCAFE_F00D, 1'b0);
        check("rdata_held_after_store", rdata2, 32'd1);
        idle(1);

        // Reset in the middle of a pending store.
        drive(1'b1, 1'b1, 1'b1, 5'd3, 32'd7);
        @(negedge clk);
        check("midwait_stall_c0", {31'd0, stall2}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("midwait_stall_c1", {31'd0, stall2}, 32'd1);
        do_reset(1);
        idle(3);
`ifdef DMEM_PERF_CNT_EN
        check("cnt_after_reset", cnt2, 32'd0);
`endif
        access(1'b1, 1'b0, 5'd3, 32'd0, 1'b0);
        check("abandoned_store", rdata2, 32'd0);
        access(1'b1, 1'b0, 5'd5, 32'd0, 1'b0);
        check("mem_cleared", rdata2, 32'd0);

        // Randomized traffic on both instances.
        for (int i = 0; i < 40; i++) begin
            access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 31)), $urandom, 1'b1);
            if ($urandom_range(0, 2) == 0) idle(1);
        end
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
